// File: rtl/adc_framer_pkg.sv
// Shared types for the stereo ADC framer: frame layout, pairing states, counter helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc_framer_pkg;

    localparam int SAMPLE_W_DEF = 12;

    // Left channel occupies the MSBs of a frame.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_L,
        HAVE_R
    } pair_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO: head entry visible on o_dout whenever !o_empty.
// Latency: push on cycle N is visible at the head on N+1 when the FIFO was empty.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
// Ports: clock/reset, i_push/i_din write side, i_pop/o_dout read side,
//        o_full/o_empty/o_level occupancy status.
module sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Gate the head so the output reads zero when nothing is stored.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/adc_stereo_framer.sv
// Pairs independent left/right sample strobes into stereo frames and queues them.
// Latency: completing strobe on cycle N -> out_valid on N+1 when the queue was empty.
// Backpressure: out_ready stalls the queue; frames arriving while full are dropped and counted.
// Ports: clock/reset, enable, clear_stats, ldata/lstrb, rdata/rstrb inputs;
//        out_data/out_valid/out_ready stream; fifo_level, overflow_cnt, desync_cnt status.
// The frame layout follows the package sample width, so SAMPLE_W must equal SAMPLE_W_DEF.
module adc_stereo_framer
    import adc_framer_pkg::*;
#(
    parameter int SAMPLE_W     = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH   = 8,
    parameter int PAIR_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear_stats,
    input  logic [SAMPLE_W-1:0]           ldata,
    input  logic                          lstrb,
    input  logic [SAMPLE_W-1:0]           rdata,
    input  logic                          rstrb,
    output logic [2*SAMPLE_W-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              overflow_cnt,
    output logic [CNT_W-1:0]              desync_cnt
);

    localparam int TMO_W = $clog2(PAIR_TIMEOUT + 1);

    pair_state_t         r_state, w_state_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [SAMPLE_W-1:0] r_left, w_left_nxt;
    logic [SAMPLE_W-1:0] r_right, w_right_nxt;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic [CNT_W-1:0]    r_dsy_cnt;
    frame_t              w_frame;
    logic                w_push;
    logic                w_desync;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TMO_W'(PAIR_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_nxt     = r_tmo;
        w_left_nxt    = r_left;
        w_right_nxt   = r_right;
        w_push        = 1'b0;
        w_desync      = 1'b0;
        w_frame.left  = ldata;
        w_frame.right = rdata;
        if (!enable) begin
            // Disabling drops any half pair silently.
            w_state_nxt = IDLE;
            w_tmo_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_tmo_nxt = '0;
                    if (lstrb && rstrb) begin
                        w_push = 1'b1;
                    end else if (lstrb) begin
                        w_left_nxt  = ldata;
                        w_state_nxt = HAVE_L;
                    end else if (rstrb) begin
                        w_right_nxt = rdata;
                        w_state_nxt = HAVE_R;
                    end
                end
                HAVE_L: begin
                    if (rstrb) begin
                        // A fresh left alongside the partner supersedes the held one.
                        w_frame.left = lstrb ? ldata : r_left;
                        w_push       = 1'b1;
                        w_desync     = lstrb;
                        w_state_nxt  = IDLE;
                        w_tmo_nxt    = '0;
                    end else if (lstrb) begin
                        w_left_nxt = ldata;
                        w_desync   = 1'b1;
                        w_tmo_nxt  = '0;
                    end else if (w_tmo_hit) begin
                        w_desync    = 1'b1;
                        w_state_nxt = IDLE;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    end
                end
                HAVE_R: begin
                    if (lstrb) begin
                        w_frame.right = rstrb ? rdata : r_right;
                        w_push        = 1'b1;
                        w_desync      = rstrb;
                        w_state_nxt   = IDLE;
                        w_tmo_nxt     = '0;
                    end else if (rstrb) begin
                        w_right_nxt = rdata;
                        w_desync    = 1'b1;
                        w_tmo_nxt   = '0;
                    end else if (w_tmo_hit) begin
                        w_desync    = 1'b1;
                        w_state_nxt = IDLE;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tmo_nxt   = '0;
                end
            endcase
        end
    end

    assign w_pop = out_valid & out_ready;

    sync_fifo #(
        .W     (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_frame),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign out_valid = ~w_empty;

    // Clearing wins over an increment landing on the same edge.
    always_ff @(posedge clock) begin
        if (reset || clear_stats) begin
            r_ovf_cnt <= '0;
            r_dsy_cnt <= '0;
        end else begin
            if (w_push && w_full && !w_pop) r_ovf_cnt <= CNT_W'(sat_inc(32'(r_ovf_cnt), CNT_W));
            if (w_desync)                   r_dsy_cnt <= CNT_W'(sat_inc(32'(r_dsy_cnt), CNT_W));
        end
    end

    assign overflow_cnt = r_ovf_cnt;
    assign desync_cnt   = r_dsy_cnt;

endmodule

// File: tb/tb_adc_stereo_framer.sv
module tb_adc_stereo_framer;

    localparam int DEPTH = 8;
    localparam int TO    = 64;

    logic        clock = 1'b0;
    logic        reset, enable, clear_stats, lstrb, rstrb, out_ready;
    logic [11:0] ldata, rdata;
    logic [23:0] out_data;
    logic        out_valid;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_cnt, desync_cnt;

    adc_stereo_framer dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .ldata        (ldata),
        .lstrb        (lstrb),
        .rdata        (rdata),
        .rstrb        (rstrb),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .desync_cnt   (desync_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: queue of frames, pending half-pair with its latch time.
    logic [23:0] q[$];
    int          pend_side;   // 0 none, 1 left held, 2 right held
    logic [11:0] pend_val;
    int          t_latch;
    int          cyc;
    int          m_ovf, m_dsy;
    int          vectors, miscompares, nchk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          pop, full, have_f;
        int          dinc;
        logic [23:0] f;
        have_f = 0;
        dinc   = 0;
        f      = '0;
        if (reset) begin
            q.delete();
            pend_side = 0;
            m_ovf = 0;
            m_dsy = 0;
        end else begin
            pop  = (q.size() != 0) && out_ready;
            full = (q.size() == DEPTH);
            if (!enable) begin
                pend_side = 0;
            end else if (pend_side == 1) begin
                if (rstrb) begin
                    f = {(lstrb ? ldata : pend_val), rdata}; have_f = 1;
                    dinc = lstrb ? 1 : 0; pend_side = 0;
                end else if (lstrb) begin
                    pend_val = ldata; t_latch = cyc; dinc = 1;
                end else if (cyc - t_latch == TO) begin
                    dinc = 1; pend_side = 0;
                end
            end else if (pend_side == 2) begin
                if (lstrb) begin
                    f = {ldata, (rstrb ? rdata : pend_val)}; have_f = 1;
                    dinc = rstrb ? 1 : 0; pend_side = 0;
                end else if (rstrb) begin
                    pend_val = rdata; t_latch = cyc; dinc = 1;
                end else if (cyc - t_latch == TO) begin
                    dinc = 1; pend_side = 0;
                end
            end else begin
                if (lstrb && rstrb) begin
                    f = {ldata, rdata}; have_f = 1;
                end else if (lstrb) begin
                    pend_side = 1; pend_val = ldata; t_latch = cyc;
                end else if (rstrb) begin
                    pend_side = 2; pend_val = rdata; t_latch = cyc;
                end
            end
            if (pop) void'(q.pop_front());
            if (clear_stats) begin
                m_ovf = 0;
                m_dsy = 0;
            end else begin
                if (have_f && full && !pop && m_ovf < 65535) m_ovf++;
                if (dinc != 0 && m_dsy < 65535) m_dsy++;
            end
            if (have_f && (!full || pop)) q.push_back(f);
        end
        cyc++;
        @(posedge clock);
        #1;
        vectors++;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("level", 32'(fifo_level), 32'(q.size()));
        chk("ovf_cnt", 32'(overflow_cnt), 32'(m_ovf));
        chk("dsy_cnt", 32'(desync_cnt), 32'(m_dsy));
        lstrb = 0; rstrb = 0; clear_stats = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sl(input logic [11:0] v);
        lstrb = 1; ldata = v; tick();
    endtask

    task automatic sr(input logic [11:0] v);
        rstrb = 1; rdata = v; tick();
    endtask

    task automatic sb(input logic [11:0] l, input logic [11:0] r);
        lstrb = 1; rstrb = 1; ldata = l; rdata = r; tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0; nchk = 0; cyc = 0;
        pend_side = 0; pend_val = '0; t_latch = 0; m_ovf = 0; m_dsy = 0;
        reset = 1; enable = 0; clear_stats = 0; lstrb = 0; rstrb = 0;
        ldata = '0; rdata = '0; out_ready = 0;
        idle(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset = 0; enable = 1; out_ready = 1;
        idle(2);

        // Left then right five clocks later.
        sl(12'h123);
        idle(4);
        sr(12'hABC);
        chk("pair_valid", 32'(out_valid), 32'd1);
        chk("pair_data", 32'(out_data), 32'h123ABC);
        chk("pair_dsy", 32'(desync_cnt), 32'd0);
        idle(2);

        // Both strobes together.
        sb(12'hFFF, 12'h001);
        chk("sim_data", 32'(out_data), 32'hFFF001);
        idle(2);

        // Ten pairs into a stalled FIFO of eight.
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            sl(12'($urandom_range(0, 4095)));
            sr(12'($urandom_range(0, 4095)));
        end
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_count", 32'(overflow_cnt), 32'd2);
        out_ready = 1;
        idle(9);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Full FIFO with push and pop on the same cycle.
        out_ready = 0;
        for (int i = 0; i < 8; i++) sb(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        chk("full_level", 32'(fifo_level), 32'd8);
        out_ready = 1;
        sb(12'h5A5, 12'hA5A);
        chk("pp_level", 32'(fifo_level), 32'd8);
        chk("pp_ovf", 32'(overflow_cnt), 32'd2);
        idle(10);

        // Repeated left before right: second left wins.
        sl(12'h111);
        sl(12'h222);
        sr(12'h333);
        chk("dbl_dsy", 32'(desync_cnt), 32'd1);
        chk("dbl_data", 32'(out_data), 32'h222333);
        idle(2);

        // Partner on the last allowed cycle still pairs.
        sl(12'h0F0);
        idle(TO - 1);
        sr(12'h00F);
        chk("edge_dsy", 32'(desync_cnt), 32'd1);
        chk("edge_data", 32'(out_data), 32'h0F000F);
        idle(2);

        // Lone left times out after PAIR_TIMEOUT idle clocks.
        sl(12'h777);
        idle(TO - 1);
        chk("tmo_pre", 32'(desync_cnt), 32'd1);
        idle(1);
        chk("tmo_dsy", 32'(desync_cnt), 32'd2);
        chk("tmo_nofrm", 32'(out_valid), 32'd0);

        // Clear coincident with a desync event.
        sl(12'h444);
        clear_stats = 1;
        sl(12'h555);
        chk("clr_dsy", 32'(desync_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow_cnt), 32'd0);
        sr(12'h666);
        idle(1);

        // Reset while holding a left with frames queued.
        out_ready = 0;
        sb(12'h101, 12'h202);
        sl(12'h303);
        reset = 1;
        tick();
        chk("rstp_valid", 32'(out_valid), 32'd0);
        chk("rstp_level", 32'(fifo_level), 32'd0);
        chk("rstp_data", 32'(out_data), 32'd0);
        reset = 0; out_ready = 1;
        idle(TO + 4);
        chk("rstp_dsy", 32'(desync_cnt), 32'd0);

        // Disable drops a half pair silently.
        sl(12'h999);
        enable = 0;
        rstrb = 1; rdata = 12'h888; tick();
        enable = 1;
        sr(12'h321);
        sl(12'h654);
        chk("en_data", 32'(out_data), 32'h654321);
        chk("en_dsy", 32'(desync_cnt), 32'd0);
        idle(2);

        // Random traffic, dense then sparse strobes.
        for (int i = 0; i < 1500; i++) begin
            int p;
            p = (i < 800) ? 6 : 90;
            lstrb = ($urandom_range(0, p - 1) == 0);
            rstrb = ($urandom_range(0, p - 1) == 0);
            ldata = 12'($urandom_range(0, 4095));
            rdata = 12'($urandom_range(0, 4095));
            out_ready = ($urandom_range(0, 2) != 0);
            enable = ($urandom_range(0, 99) != 0);
            clear_stats = ($urandom_range(0, 199) == 0);
            tick();
        end
        enable = 1; out_ready = 1;
        idle(DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
